t_flip_flop: RTL and testbench

- Parameterised bank of WIDTH independent toggle (T) flip-flops sharing one clock and one asynchronous active-high reset.
- Each bit inverts its stored state on a rising clock edge when its toggle input is 1, and holds when it is 0.
- Adds a global clock enable, a synchronous parallel load, and a per-bit toggle-event pulse.
- Used as a counter/divider building block and as a lab-level T flip-flop; WIDTH=1 gives the classic single T flip-flop with Q/Qbar.

---
 rtl/t_flip_flop_pkg.sv | 31 +++
 rtl/t_ff_cell.sv | 61 ++++++
 rtl/t_flip_flop.sv | 44 ++++
 tb/tb_t_flip_flop.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/t_flip_flop_pkg.sv
// ============================================================================
// Module  : t_flip_flop_pkg
// Brief   : Shared constants and control-priority encoding for the T-FF bank
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package t_flip_flop_pkg;

  localparam int          DEFAULT_WIDTH       = 1;
  localparam logic [63:0] DEFAULT_RESET_VALUE = 64'h0;

  typedef enum logic [1:0] {
    CTRL_HOLD   = 2'd0,
    CTRL_LOAD   = 2'd1,
    CTRL_TOGGLE = 2'd2
  } ctrl_e;

  // Enable outranks load, load outranks toggle.
  function automatic ctrl_e ctrl_decode(input logic en, input logic load);
    if (!en) begin
      return CTRL_HOLD;
    end else if (load) begin
      return CTRL_LOAD;
    end
    return CTRL_TOGGLE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/t_ff_cell.sv
// ============================================================================
// Module  : t_ff_cell
// Brief   : One toggle flip-flop bit with enable, load and toggle-event pulse
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module t_ff_cell
  import t_flip_flop_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic t,
  input  logic en,
  input  logic load,
  input  logic d,
  input  logic rst_val,
  output logic q,
  output logic toggled
);

  logic  q_q, q_d;
  logic  tog_q, tog_d;
  ctrl_e w_ctrl;

  assign w_ctrl = ctrl_decode(en, load);

  // The pulse register clears in every non-toggle mode so it never stretches.
  always_comb begin
    q_d   = q_q;
    tog_d = 1'b0;
    case (w_ctrl)
      CTRL_LOAD: begin
        q_d = d;
      end
      CTRL_TOGGLE: begin
        q_d   = q_q ^ t;
        tog_d = t;
      end
      default: begin
        q_d = q_q;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q   <= rst_val;
      tog_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      tog_q <= tog_d;
    end
  end

  assign q       = q_q;
  assign toggled = tog_q;

endmodule

`default_nettype wire

// File: rtl/t_flip_flop.sv
// ============================================================================
// Module  : t_flip_flop
// Brief   : Parameterised bank of independent T flip-flops with Q/Qbar
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module t_flip_flop
  import t_flip_flop_pkg::*;
#(
  parameter int               WIDTH       = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = DEFAULT_RESET_VALUE[WIDTH-1:0]
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] t,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic [WIDTH-1:0] toggled
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    t_ff_cell u_cell (
      .clk     (clk),
      .rst     (rst),
      .t       (t[i]),
      .en      (en),
      .load    (load),
      .d       (d[i]),
      .rst_val (RESET_VALUE[i]),
      .q       (q[i]),
      .toggled (toggled[i])
    );
  end

  // Derived from q so the complement holds through reset as well.
  assign qbar = ~q;

endmodule

`default_nettype wire

// File: tb/tb_t_flip_flop.sv
// ============================================================================
// Module  : tb_t_flip_flop
// Brief   : Directed and randomized self-checking bench for three T-FF banks
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_t_flip_flop;
  import t_flip_flop_pkg::*;

  logic clk = 1'b0;
  logic rst;

  logic       t1, en1, ld1, d1;
  logic [3:0] t4, d4;
  logic       en4, ld4;
  logic [7:0] t8, d8;
  logic       en8, ld8;

  wire        q1, qb1, tg1;
  wire  [3:0] q4, qb4, tg4;
  wire  [7:0] q8, qb8, tg8;

  logic       m1_q, m1_tg;
  logic [3:0] m4_q, m4_tg;
  logic [7:0] m8_q, m8_tg;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  t_flip_flop #(.WIDTH(1), .RESET_VALUE(1'b0)) u_dut1 (
    .clk(clk), .rst(rst), .t(t1), .en(en1), .load(ld1), .d(d1),
    .q(q1), .qbar(qb1), .toggled(tg1)
  );

  t_flip_flop #(.WIDTH(4), .RESET_VALUE(4'h0)) u_dut4 (
    .clk(clk), .rst(rst), .t(t4), .en(en4), .load(ld4), .d(d4),
    .q(q4), .qbar(qb4), .toggled(tg4)
  );

  t_flip_flop #(.WIDTH(8), .RESET_VALUE(8'hA5)) u_dut8 (
    .clk(clk), .rst(rst), .t(t8), .en(en8), .load(ld8), .d(d8),
    .q(q8), .qbar(qb8), .toggled(tg8)
  );

  // Reference: returns {next q, next toggled pulse} from the priority rules.
  function automatic logic [15:0] ref_next(input logic en, input logic load,
                                           input logic [7:0] t, input logic [7:0] d,
                                           input logic [7:0] q);
    ctrl_e mode;
    mode = !en ? CTRL_HOLD : (load ? CTRL_LOAD : CTRL_TOGGLE);
    case (mode)
      CTRL_HOLD: return {q, 8'h00};
      CTRL_LOAD: return {d, 8'h00};
      default:   return {q ^ t, t};
    endcase
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "/q1"},   {7'b0, q1},  {7'b0, m1_q});
    check({tag, "/qb1"},  {7'b0, qb1}, {7'b0, ~m1_q});
    check({tag, "/tg1"},  {7'b0, tg1}, {7'b0, m1_tg});
    check({tag, "/q4"},   {4'b0, q4},  {4'b0, m4_q});
    check({tag, "/qb4"},  {4'b0, qb4}, {4'b0, ~m4_q});
    check({tag, "/tg4"},  {4'b0, tg4}, {4'b0, m4_tg});
    check({tag, "/q8"},   q8,  m8_q);
    check({tag, "/qb8"},  qb8, ~m8_q);
    check({tag, "/tg8"},  tg8, m8_tg);
  endtask

  task automatic model_reset();
    m1_q = 1'b0; m1_tg = 1'b0;
    m4_q = 4'h0; m4_tg = 4'h0;
    m8_q = 8'hA5; m8_tg = 8'h00;
  endtask

  task automatic step(input string tag);
    logic [15:0] r;
    @(posedge clk);
    if (!rst) begin
      r = ref_next(en1, ld1, {7'b0, t1}, {7'b0, d1}, {7'b0, m1_q});
      m1_q = r[8];  m1_tg = r[0];
      r = ref_next(en4, ld4, {4'b0, t4}, {4'b0, d4}, {4'b0, m4_q});
      m4_q = r[11:8]; m4_tg = r[3:0];
      r = ref_next(en8, ld8, t8, d8, m8_q);
      m8_q = r[15:8]; m8_tg = r[7:0];
    end
    #1 check_all(tag);
  endtask

  // Called shortly after an edge; checks effect before the next edge.
  task automatic async_reset(input string tag);
    rst = 1'b1;
    #2;
    model_reset();
    check_all(tag);
  endtask

  initial begin
    int q_seq [7];
    int t_seq [7];
    int rises;
    logic prev;

    t_seq = '{1, 1, 0, 1, 0, 1, 1};
    q_seq = '{1, 0, 0, 1, 1, 0, 1};

    rst = 1'b1;
    t1 = 1'b1; en1 = 1'b1; ld1 = 1'b0; d1 = 1'b0;
    t4 = 4'h0; en4 = 1'b1; ld4 = 1'b0; d4 = 4'h0;
    t8 = 8'h00; en8 = 1'b1; ld8 = 1'b0; d8 = 8'h00;
    model_reset();

    // Reset is visible before any clock edge.
    #2;
    check_all("reset_async");
    check("reset_q1_const", {7'b0, q1}, 8'h00);
    check("reset_q8_const", q8, 8'hA5);
    step("reset_hold_edge");

    rst = 1'b0; t1 = 1'b0;
    step("release0");
    step("release1");
    check("release_q1_const", {7'b0, q1}, 8'h00);

    for (int i = 0; i < 7; i++) begin
      t1 = t_seq[i][0];
      step("tseq");
      check("tseq_q_const",   {7'b0, q1},  8'(q_seq[i]));
      check("tseq_tg_const",  {7'b0, tg1}, 8'(t_seq[i]));
      check("tseq_qb_const",  {7'b0, qb1}, 8'(1 - q_seq[i]));
    end

    async_reset("midreset");
    check("midreset_q1_const", {7'b0, q1}, 8'h00);
    t1 = 1'b1;
    step("midreset_hold0");
    step("midreset_hold1");
    rst = 1'b0;
    step("midreset_release");
    check("midreset_release_q1", {7'b0, q1}, 8'h01);

    t1 = 1'b0;
    en4 = 1'b0; ld4 = 1'b1; d4 = 4'b1010; t4 = 4'hF;
    step("en0_load");
    check("en0_load_q4_const", {4'b0, q4}, 8'h00);
    en4 = 1'b1;
    step("en1_load");
    check("en1_load_q4_const",  {4'b0, q4},  8'h0A);
    check("en1_load_tg4_const", {4'b0, tg4}, 8'h00);
    ld4 = 1'b0; t4 = 4'b0110;
    step("after_load_toggle");
    check("after_load_q4_const",  {4'b0, q4},  8'h0C);
    check("after_load_tg4_const", {4'b0, tg4}, 8'h06);

    t4 = 4'h0; t8 = 8'h0F;
    step("indep0");
    check("indep0_q8",  q8,  8'hAA);
    check("indep0_qb8", qb8, 8'h55);
    step("indep1");
    check("indep1_q8",  q8,  8'hA5);
    check("indep1_qb8", qb8, 8'h5A);
    step("indep2");
    check("indep2_q8",  q8,  8'hAA);
    check("indep2_qb8", qb8, 8'h55);
    t8 = 8'h00;

    t1 = 1'b1;
    rises = 0;
    for (int i = 0; i < 16; i++) begin
      prev = q1;
      step("div2");
      check("div2_toggle", {7'b0, q1 ^ prev}, 8'h01);
      check("div2_tg1",    {7'b0, tg1},       8'h01);
      if (!prev && q1) rises++;
    end
    check("div2_rises", 8'(rises), 8'd8);

    for (int i = 0; i < 300; i++) begin
      t1 = 1'($urandom); d1 = 1'($urandom);
      en1 = ($urandom_range(0, 3) != 0); ld1 = ($urandom_range(0, 4) == 0);
      t4 = 4'($urandom); d4 = 4'($urandom);
      en4 = ($urandom_range(0, 3) != 0); ld4 = ($urandom_range(0, 4) == 0);
      t8 = 8'($urandom); d8 = 8'($urandom);
      en8 = ($urandom_range(0, 3) != 0); ld8 = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 39) == 0) begin
        async_reset("rnd_reset");
        step("rnd_reset_hold");
        rst = 1'b0;
      end else begin
        step("rnd");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
